// File: rtl/block_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : block_loader_pkg
//  Description : Shared constants and state encoding for the 8x8 block loader.
//  Revision    : 1.0
// ============================================================================
package block_loader_pkg;

    localparam int ROW_BITS = 64;
    localparam int BLK_PIX  = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/block_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : block_loader_if
//  Description : Pixel-in / row-out bundle between the feeder and the loader.
//  Revision    : 1.0
// ============================================================================
interface block_loader_if;
    import block_loader_pkg::*;

    logic [7:0]          cur_pix;
    logic [7:0]          ref_in;
    logic                pix_valid;
    logic                pix_ready;
    logic [ROW_BITS-1:0] filter_pix;
    logic [ROW_BITS-1:0] ref_pix;
    logic                input_ready;
    logic                row_valid;
    logic [2:0]          row_idx;

    modport slave (
        input  cur_pix, ref_in, pix_valid,
        output pix_ready, filter_pix, ref_pix, input_ready, row_valid, row_idx
    );

    modport master (
        output cur_pix, ref_in, pix_valid,
        input  pix_ready, filter_pix, ref_pix, input_ready, row_valid, row_idx
    );
endinterface
`default_nettype wire

// File: rtl/block_buf.sv
`default_nettype none
// ============================================================================
//  Module      : block_buf
//  Description : Byte register array with one write port and a whole-row read.
//  Revision    : 1.0
// ============================================================================
module block_buf #(
    parameter  int ROWS     = 8,
    parameter  int COLS     = 8,
    parameter  int PIX_BITS = 8,
    localparam int RW       = $clog2(ROWS),
    localparam int CW       = $clog2(COLS)
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [RW-1:0]            wr_row,
    input  wire logic [CW-1:0]            wr_col,
    input  wire logic [PIX_BITS-1:0]      wr_data,
    input  wire logic [RW-1:0]            rd_row,
    output logic      [COLS*PIX_BITS-1:0] rd_data
);

    logic [PIX_BITS-1:0] r_mem [ROWS][COLS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Column c of the selected row lands in byte lane c of the row word.
    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign rd_data[c*PIX_BITS +: PIX_BITS] = r_mem[rd_row][c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/block_loader.sv
`default_nettype none
// ============================================================================
//  Module      : block_loader
//  Description : Buffers a raster 8x8 cur/ref block pair, then streams 8 rows.
//  Revision    : 1.0
// ============================================================================
module block_loader
    import block_loader_pkg::*;
#(
    parameter int HEIGHT   = 8,
    parameter int WIDTH    = 8,
    parameter int PIX_BITS = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    block_loader_if.slave bus
);

    state_t              r_state;
    logic [5:0]          r_beat;
    logic [2:0]          r_row;
    logic                r_input_ready;
    logic                r_row_valid;
    logic [ROW_BITS-1:0] r_filter_pix;
    logic [ROW_BITS-1:0] r_ref_pix;

    logic                w_accept;
    logic [2:0]          w_rd_row;
    logic [ROW_BITS-1:0] w_cur_row;
    logic [ROW_BITS-1:0] w_ref_row;

    assign w_accept = (r_state == LOAD) && bus.pix_valid;
    // Read address runs one row ahead of the presented row so the output regs
    // pick up the next row on the edge that advances the counter.
    assign w_rd_row = (r_state == START) ? 3'd0 : r_row + 3'd1;

    block_buf #(.ROWS(HEIGHT), .COLS(WIDTH), .PIX_BITS(PIX_BITS)) u_cur_buf (
        .clk     (clk),
        .we      (w_accept),
        .wr_row  (r_beat[5:3]),
        .wr_col  (r_beat[2:0]),
        .wr_data (bus.cur_pix),
        .rd_row  (w_rd_row),
        .rd_data (w_cur_row)
    );

    block_buf #(.ROWS(HEIGHT), .COLS(WIDTH), .PIX_BITS(PIX_BITS)) u_ref_buf (
        .clk     (clk),
        .we      (w_accept),
        .wr_row  (r_beat[5:3]),
        .wr_col  (r_beat[2:0]),
        .wr_data (bus.ref_in),
        .rd_row  (w_rd_row),
        .rd_data (w_ref_row)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= LOAD;
            r_beat        <= 6'd0;
            r_row         <= 3'd0;
            r_input_ready <= 1'b0;
            r_row_valid   <= 1'b0;
            r_filter_pix  <= '0;
            r_ref_pix     <= '0;
        end else begin
            r_input_ready <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_row_valid <= 1'b0;
                    if (w_accept) begin
                        r_beat <= r_beat + 6'd1;
                        if (r_beat == 6'(BLK_PIX - 1)) begin
                            r_state       <= START;
                            r_input_ready <= 1'b1;
                        end
                    end
                end
                START: begin
                    r_state      <= SEND;
                    r_row        <= 3'd0;
                    r_row_valid  <= 1'b1;
                    r_filter_pix <= w_cur_row;
                    r_ref_pix    <= w_ref_row;
                end
                SEND: begin
                    if (r_row == 3'(HEIGHT - 1)) begin
                        r_state     <= LOAD;
                        r_row       <= 3'd0;
                        r_row_valid <= 1'b0;
                    end else begin
                        r_row        <= r_row + 3'd1;
                        r_filter_pix <= w_cur_row;
                        r_ref_pix    <= w_ref_row;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign bus.pix_ready   = (r_state == LOAD);
    assign bus.input_ready = r_input_ready;
    assign bus.row_valid   = r_row_valid;
    assign bus.row_idx     = r_row;
    assign bus.filter_pix  = r_filter_pix;
    assign bus.ref_pix     = r_ref_pix;

endmodule
`default_nettype wire
